// File: rtl/alu_seq_if.sv
// Request/response bundle of the sequential ALU: operands and opcode in,
// handshake, registered result and flags out.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       aluc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] r;
    logic             zero;
    logic             carry;
    logic             negative;
    logic             overflow;

    modport master (
        output start, aluc, a, b,
        input  busy, done, r, zero, carry, negative, overflow
    );

    modport slave (
        input  start, aluc, a, b,
        output busy, done, r, zero, carry, negative, overflow
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake. Arithmetic, logic, LUI and
// set-less-than complete in one cycle; shifts walk one bit per cycle through
// a working register so no barrel shifter is needed.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);
    // Counter must hold WIDTH+1, the saturated shift count.
    localparam int               CW    = $clog2(WIDTH + 2);
    localparam logic [WIDTH-1:0] NMAX  = WIDTH'(WIDTH + 1);
    localparam logic [CW-1:0]    CMAX  = CW'(WIDTH + 1);
    localparam logic [CW-1:0]    CONE  = CW'(1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    // Shift kind, taken straight from aluc[1:0] at acceptance.
    localparam logic [1:0] SOP_SRA = 2'b00;
    localparam logic [1:0] SOP_SRL = 2'b01;

    logic [0:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_work;
    logic [1:0]       r_sop;
    logic [WIDTH-1:0] r_r;
    logic             r_zero;
    logic             r_carry;
    logic             r_neg;
    logic             r_ovf;
    logic             r_done;

    logic             w_is_shift;
    logic [CW-1:0]    w_cnt_init;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_zero;
    logic             w_carry;
    logic             w_neg;
    logic             w_ovf;
    logic [WIDTH-1:0] w_step;
    logic             w_bit;

    assign w_is_shift = bus.aluc[3] & bus.aluc[2];
    // Shifting more than WIDTH+1 times cannot change the outcome, so saturate.
    assign w_cnt_init = (bus.a > NMAX) ? CMAX : bus.a[CW-1:0];
    assign w_sum      = {1'b0, bus.a} + {1'b0, bus.b};
    // Top bit of the widened difference is the unsigned borrow (a < b).
    assign w_diff     = {1'b0, bus.a} - {1'b0, bus.b};

    // Single-cycle result and flags; a zero-count shift passes b through.
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (bus.aluc)
            4'b0000: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            4'b0010: begin
                w_res = w_sum[WIDTH-1:0];
                w_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'b0001: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
            end
            4'b0011: begin
                w_res = w_diff[WIDTH-1:0];
                w_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'b0100: w_res = bus.a & bus.b;
            4'b0101: w_res = bus.a | bus.b;
            4'b0110: w_res = bus.a ^ bus.b;
            4'b0111: w_res = ~(bus.a | bus.b);
            4'b1000,
            4'b1001: w_res = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            4'b1011: w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            4'b1010: begin
                w_res   = {{(WIDTH-1){1'b0}}, w_diff[WIDTH]};
                w_carry = w_diff[WIDTH];
            end
            default: w_res = bus.b;
        endcase
        // Set-less-than ops report equality in zero instead of r==0.
        if (bus.aluc == 4'b1011 || bus.aluc == 4'b1010) begin
            w_zero = (bus.a == bus.b);
            w_neg  = (bus.aluc == 4'b1011) ? w_res[0] : w_res[WIDTH-1];
        end else begin
            w_zero = (w_res == '0);
            w_neg  = w_res[WIDTH-1];
        end
    end

    // One step of the iterative shifter and the bit that falls off.
    always_comb begin
        case (r_sop)
            SOP_SRA: begin
                w_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
                w_bit  = r_work[0];
            end
            SOP_SRL: begin
                w_step = {1'b0, r_work[WIDTH-1:1]};
                w_bit  = r_work[0];
            end
            default: begin
                w_step = {r_work[WIDTH-2:0], 1'b0};
                w_bit  = r_work[WIDTH-1];
            end
        endcase
    end

    // Control FSM, working register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
            r_sop   <= '0;
            r_r     <= '0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
            r_neg   <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (w_is_shift && (w_cnt_init != '0)) begin
                            r_state <= SHIFT;
                            r_cnt   <= w_cnt_init;
                            r_work  <= bus.b;
                            r_sop   <= bus.aluc[1:0];
                        end else begin
                            r_r     <= w_res;
                            r_zero  <= w_zero;
                            r_carry <= w_carry;
                            r_neg   <= w_neg;
                            r_ovf   <= w_ovf;
                            r_done  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    r_work <= w_step;
                    r_cnt  <= r_cnt - CONE;
                    // Last step: publish the shifted value directly.
                    if (r_cnt == CONE) begin
                        r_state <= IDLE;
                        r_r     <= w_step;
                        r_zero  <= (w_step == '0);
                        r_carry <= w_bit;
                        r_neg   <= w_step[WIDTH-1];
                        r_ovf   <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = (r_state == SHIFT);
    assign bus.done     = r_done;
    assign bus.r        = r_r;
    assign bus.zero     = r_zero;
    assign bus.carry    = r_carry;
    assign bus.negative = r_neg;
    assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=32: directed cases plus random operations
// checked against an arithmetic reference model.
module tb_alu_seq;
    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        c;
        logic        n;
        logic        v;
    } res_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t sample();
        return {bus.r, bus.zero, bus.carry, bus.negative, bus.overflow};
    endfunction

    // Reference: results from plain 64-bit arithmetic, latency from the count.
    function automatic res_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output int lat);
        res_t            e;
        longint unsigned ua, ub, t;
        longint          sa, sb, s;
        int              n;
        e  = '0;
        lat = 1;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0: begin t = ua + ub; e.r = t[31:0]; e.c = t[32]; end
            4'd2: begin s = sa + sb; e.r = s[31:0];
                        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd1: begin e.r = a - b; e.c = (ua < ub); end
            4'd3: begin s = sa - sb; e.r = s[31:0];
                        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd4: e.r = a & b;
            4'd5: e.r = a | b;
            4'd6: e.r = a ^ b;
            4'd7: e.r = ~(a | b);
            4'd8, 4'd9: e.r = b << 16;
            4'd11: e.r = {31'd0, (sa < sb)};
            4'd10: begin e.r = {31'd0, (ua < ub)}; e.c = (ua < ub); end
            default: begin
                n   = (ua > 33) ? 33 : int'(ua);
                lat = n + 1;
                if (op == 4'd12) begin
                    s = sb >>> n; e.r = s[31:0];
                    e.c = (n == 0) ? 1'b0 : sb[n-1];
                end else if (op == 4'd13) begin
                    t = ub >> n; e.r = t[31:0];
                    e.c = (n == 0) ? 1'b0 : ub[n-1];
                end else begin
                    t = ub << n; e.r = t[31:0];
                    e.c = t[32];
                end
            end
        endcase
        if (op == 4'd11) begin
            e.z = (a == b); e.n = e.r[0];
        end else if (op == 4'd10) begin
            e.z = (a == b); e.n = e.r[31];
        end else begin
            e.z = (e.r == 32'd0); e.n = e.r[31];
        end
        return e;
    endfunction

    // Drives one request, scrambles inputs afterwards, waits (bounded) for done.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output res_t got, output int lat, output int busy_cyc,
                         output int overlap);
        @(negedge clk);
        bus.start = 1'b1;
        bus.aluc  = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.aluc  = 4'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
        lat = 1;
        busy_cyc = 0;
        overlap = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) busy_cyc++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (bus.busy && bus.done) overlap++;
        got = sample();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({sample(), bus.busy, bus.done} !== 39'd0) begin
            errors++;
            $display("FAIL reset_state got %h expected 0", {sample(), bus.busy, bus.done});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add_overflow();
        res_t got; int lat, bc, ov;
        issue(4'b0010, 32'h7FFFFFFF, 32'h1, got, lat, bc, ov);
        checks++;
        if (got !== {32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1} || lat !== 1) begin
            errors++;
            $display("FAIL add_ovf got %h lat %0d expected %h lat 1", got, lat,
                     {32'h80000000, 4'b0011});
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL add_done_pulse got done=%b expected 0", bus.done);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.start = 1'b1; bus.aluc = 4'b0000; bus.a = 32'hFFFFFFFF; bus.b = 32'h1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.done, sample()} !== {1'b1, 32'h0, 4'b1100}) begin
            errors++;
            $display("FAIL b2b_addu got done=%b %h expected done=1 %h", bus.done, sample(),
                     {32'h0, 4'b1100});
        end
        bus.aluc = 4'b0001; bus.a = 32'h3; bus.b = 32'h5;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.done, sample()} !== {1'b1, 32'hFFFFFFFE, 4'b0110}) begin
            errors++;
            $display("FAIL b2b_subu got done=%b %h expected done=1 %h", bus.done, sample(),
                     {32'hFFFFFFFE, 4'b0110});
        end
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got done=%b expected 0", bus.done);
        end
    endtask

    task automatic test_sra();
        res_t got; int lat, bc, ov;
        issue(4'b1100, 32'd4, 32'h80000010, got, lat, bc, ov);
        checks++;
        if (got !== {32'hF8000001, 4'b0010} || lat !== 5 || bc !== 4 || ov !== 0) begin
            errors++;
            $display("FAIL sra got %h lat %0d busy %0d expected %h lat 5 busy 4", got, lat, bc,
                     {32'hF8000001, 4'b0010});
        end
    endtask

    task automatic test_shift_bounds();
        res_t got; int lat, bc, ov;
        issue(4'b1101, 32'd32, 32'h80000000, got, lat, bc, ov);
        checks++;
        if (got !== {32'h0, 4'b1100} || lat !== 33) begin
            errors++;
            $display("FAIL srl32 got %h lat %0d expected %h lat 33", got, lat, {32'h0, 4'b1100});
        end
        issue(4'b1110, 32'd40, 32'h1, got, lat, bc, ov);
        checks++;
        if (got !== {32'h0, 4'b1000} || lat !== 34 || bc !== 33) begin
            errors++;
            $display("FAIL sll40 got %h lat %0d busy %0d expected %h lat 34 busy 33", got, lat,
                     bc, {32'h0, 4'b1000});
        end
        issue(4'b1111, 32'd0, 32'h5, got, lat, bc, ov);
        checks++;
        if (got !== {32'h5, 4'b0000} || lat !== 1 || bc !== 0) begin
            errors++;
            $display("FAIL sll0 got %h lat %0d expected %h lat 1", got, lat, {32'h5, 4'b0000});
        end
        issue(4'b1100, 32'hFFFF0000, 32'h80000000, got, lat, bc, ov);
        checks++;
        if (got !== {32'hFFFFFFFF, 4'b0110} || lat !== 34) begin
            errors++;
            $display("FAIL sra_big got %h lat %0d expected %h lat 34", got, lat,
                     {32'hFFFFFFFF, 4'b0110});
        end
    endtask

    task automatic test_slt();
        res_t got; int lat, bc, ov;
        issue(4'b1011, 32'hFFFFFFFF, 32'h1, got, lat, bc, ov);
        checks++;
        if (got !== {32'h1, 4'b0010} || lat !== 1) begin
            errors++;
            $display("FAIL slt got %h lat %0d expected %h", got, lat, {32'h1, 4'b0010});
        end
        issue(4'b1010, 32'hFFFFFFFF, 32'h1, got, lat, bc, ov);
        checks++;
        if (got !== {32'h0, 4'b0000} || lat !== 1) begin
            errors++;
            $display("FAIL sltu got %h lat %0d expected %h", got, lat, {32'h0, 4'b0000});
        end
    endtask

    task automatic test_ignore_and_abort();
        res_t got, prev, exp; int lat, bc, ov, dones, elat;
        prev = sample();
        @(negedge clk);
        bus.start = 1'b1; bus.aluc = 4'b1101; bus.a = 32'd20; bus.b = $urandom | 32'h1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dones = 0;
        for (int c = 1; c <= 9; c++) begin
            if (c == 3) begin
                bus.start = 1'b1; bus.aluc = 4'b0100; bus.a = $urandom; bus.b = $urandom;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) dones++;
        end
        checks++;
        if (bus.busy !== 1'b1 || dones !== 0 || sample() !== prev) begin
            errors++;
            $display("FAIL ignore_start got busy=%b dones=%0d r=%h expected busy=1 dones=0 r=%h",
                     bus.busy, dones, sample(), prev);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sample(), bus.busy, bus.done} !== 39'd0) begin
            errors++;
            $display("FAIL abort_reset got %h expected 0", {sample(), bus.busy, bus.done});
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d done pulses expected 0", dones);
        end
        exp = model(4'b0100, 32'hF0F0A5A5, 32'h3C3CFFFF, elat);
        issue(4'b0100, 32'hF0F0A5A5, 32'h3C3CFFFF, got, lat, bc, ov);
        checks++;
        if (got !== exp || lat !== elat) begin
            errors++;
            $display("FAIL post_reset_and got %h lat %0d expected %h lat %0d", got, lat, exp, elat);
        end
    endtask

    task automatic test_random();
        res_t got, exp; int lat, bc, ov, elat;
        logic [3:0] op; logic [31:0] a, b;
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom);
            a  = $urandom;
            b  = $urandom;
            if (op[3] && op[2] && ($urandom_range(0, 3) != 0)) a = $urandom_range(0, 40);
            if ($urandom_range(0, 7) == 0) b = a;
            exp = model(op, a, b, elat);
            issue(op, a, b, got, lat, bc, ov);
            checks++;
            if (got !== exp || lat !== elat || ov !== 0 || bc !== elat - 1) begin
                errors++;
                $display("FAIL random op=%h a=%h b=%h got %h lat %0d busy %0d expected %h lat %0d",
                         op, a, b, got, lat, bc, exp, elat);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        bus.start = 1'b0;
        bus.aluc  = 4'd0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_sra();
        test_shift_bounds();
        test_slt();
        test_ignore_and_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
